// File: rtl/rvj1_wb_sram_bridge_pkg.sv
// Shared definitions for the Wishbone-to-SRAM bridge: base address,
// SRAM word-address width, FSM state encoding and the address decoder.
package rvj1_wb_sram_bridge_pkg;

  // Wishbone byte address of IRAM word 0; DRAM follows directly after IRAM.
  localparam logic [31:0] RVJ1_IRAM_BASE_ADDR   = 32'h3000_0000;
  // Word-address width of each SRAM macro (512 words of 32 bits).
  localparam int          IRAM_ADDR_WIDTH_WORDS = 9;

  // Bridge FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_ACK  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_ACK  = 2'd3
  } state_t;

  // Decoded target of an access.
  typedef enum logic [1:0] {
    RG_NONE = 2'd0,
    RG_IRAM = 2'd1,
    RG_DRAM = 2'd2
  } region_t;

  // IRAM occupies offsets [0, 2^(aw+2)), DRAM the next equally sized window;
  // anything else (including addresses below the base, which wrap) is unmapped.
  function automatic region_t decode_region(input logic [31:0] offset, input int aw);
    region_t rg;
    if ((offset >> (aw + 2)) == 32'd0) begin
      rg = RG_IRAM;
    end else if ((offset >> (aw + 2)) == 32'd1) begin
      rg = RG_DRAM;
    end else begin
      rg = RG_NONE;
    end
    return rg;
  endfunction

endpackage

// File: rtl/rvj1_wb_sram_bridge.sv
// Wishbone classic slave bridging to two single-port SRAM macros (IRAM, DRAM).
// All SRAM control outputs are registered. Each access strobes exactly one
// chip select for one cycle; unmapped accesses walk the same FSM path without
// touching either SRAM and read back zero.
//
// Handshake: a request is accepted only in IDLE when cyc&stb are high and no
// ack is currently being presented; wbs_ack_o is a one-cycle registered pulse,
// sampled by the master two edges (write) or three edges (read) after the
// request edge. Dropping cyc aborts the access with no ack.
module rvj1_wb_sram_bridge
  import rvj1_wb_sram_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RVJ1_IRAM_BASE_ADDR,
  parameter int          AW        = IRAM_ADDR_WIDTH_WORDS
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          iram_clk0,
  output logic          iram_csb0,
  output logic          iram_web0,
  output logic [3:0]    iram_wmask0,
  output logic [AW-1:0] iram_addr0,
  output logic [31:0]   iram_din0,
  input  logic [31:0]   iram_dout0,
  output logic          dram_clk0,
  output logic          dram_csb0,
  output logic          dram_web0,
  output logic [3:0]    dram_wmask0,
  output logic [AW-1:0] dram_addr0,
  output logic [31:0]   dram_din0,
  input  logic [31:0]   dram_dout0,
  output state_t        o_dbg_state
);

  logic [31:0]   w_offset;
  logic [AW-1:0] w_word;
  region_t       w_region;
  logic          w_req;

  state_t        r_state,  w_state_nxt;
  region_t       r_region, w_region_nxt;
  logic          r_ack,    w_ack_nxt;
  logic [31:0]   r_dat,    w_dat_nxt;

  logic          r_iram_csb,   w_iram_csb_nxt;
  logic          r_iram_web,   w_iram_web_nxt;
  logic [3:0]    r_iram_wmask, w_iram_wmask_nxt;
  logic [AW-1:0] r_iram_addr,  w_iram_addr_nxt;
  logic [31:0]   r_iram_din,   w_iram_din_nxt;

  logic          r_dram_csb,   w_dram_csb_nxt;
  logic          r_dram_web,   w_dram_web_nxt;
  logic [3:0]    r_dram_wmask, w_dram_wmask_nxt;
  logic [AW-1:0] r_dram_addr,  w_dram_addr_nxt;
  logic [31:0]   r_dram_din,   w_dram_din_nxt;

  // Address decode; byte-lane bits [1:0] are dropped from the word address.
  assign w_offset = wbs_adr_i - BASE_ADDR;
  assign w_word   = w_offset[AW+1:2];
  assign w_region = decode_region(w_offset, AW);
  // The ack guard stops the still-asserted strobe of the finishing cycle
  // from being taken as a new request.
  assign w_req    = wbs_cyc_i && wbs_stb_i && !r_ack;

  // Next-state and next-output logic for the bridge FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_region_nxt     = r_region;
    w_ack_nxt        = 1'b0;
    w_dat_nxt        = r_dat;
    w_iram_csb_nxt   = r_iram_csb;
    w_iram_web_nxt   = r_iram_web;
    w_iram_wmask_nxt = r_iram_wmask;
    w_iram_addr_nxt  = r_iram_addr;
    w_iram_din_nxt   = r_iram_din;
    w_dram_csb_nxt   = r_dram_csb;
    w_dram_web_nxt   = r_dram_web;
    w_dram_wmask_nxt = r_dram_wmask;
    w_dram_addr_nxt  = r_dram_addr;
    w_dram_din_nxt   = r_dram_din;

    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_region_nxt = w_region;
          w_state_nxt  = wbs_we_i ? ST_WR_ACK : ST_RD_WAIT;
          if (w_region == RG_IRAM) begin
            w_iram_csb_nxt  = 1'b0;
            w_iram_web_nxt  = !wbs_we_i;
            w_iram_addr_nxt = w_word;
            if (wbs_we_i) begin
              w_iram_wmask_nxt = wbs_sel_i;
              w_iram_din_nxt   = wbs_dat_i;
            end
          end else if (w_region == RG_DRAM) begin
            w_dram_csb_nxt  = 1'b0;
            w_dram_web_nxt  = !wbs_we_i;
            w_dram_addr_nxt = w_word;
            if (wbs_we_i) begin
              w_dram_wmask_nxt = wbs_sel_i;
              w_dram_din_nxt   = wbs_dat_i;
            end
          end
        end
      end
      ST_WR_ACK: begin
        // The SRAM captured the write on this edge; release it regardless of cyc.
        w_iram_csb_nxt = 1'b1;
        w_iram_web_nxt = 1'b1;
        w_dram_csb_nxt = 1'b1;
        w_dram_web_nxt = 1'b1;
        w_ack_nxt      = wbs_cyc_i;
        w_state_nxt    = ST_IDLE;
      end
      ST_RD_WAIT: begin
        w_iram_csb_nxt = 1'b1;
        w_dram_csb_nxt = 1'b1;
        w_state_nxt    = wbs_cyc_i ? ST_RD_ACK : ST_IDLE;
      end
      ST_RD_ACK: begin
        w_state_nxt = ST_IDLE;
        if (wbs_cyc_i) begin
          w_ack_nxt = 1'b1;
          case (r_region)
            RG_IRAM: w_dat_nxt = iram_dout0;
            RG_DRAM: w_dat_nxt = dram_dout0;
            default: w_dat_nxt = 32'h0;
          endcase
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= ST_IDLE;
      r_region     <= RG_NONE;
      r_ack        <= 1'b0;
      r_dat        <= 32'h0;
      r_iram_csb   <= 1'b1;
      r_iram_web   <= 1'b1;
      r_iram_wmask <= 4'h0;
      r_iram_addr  <= '0;
      r_iram_din   <= 32'h0;
      r_dram_csb   <= 1'b1;
      r_dram_web   <= 1'b1;
      r_dram_wmask <= 4'h0;
      r_dram_addr  <= '0;
      r_dram_din   <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_region     <= w_region_nxt;
      r_ack        <= w_ack_nxt;
      r_dat        <= w_dat_nxt;
      r_iram_csb   <= w_iram_csb_nxt;
      r_iram_web   <= w_iram_web_nxt;
      r_iram_wmask <= w_iram_wmask_nxt;
      r_iram_addr  <= w_iram_addr_nxt;
      r_iram_din   <= w_iram_din_nxt;
      r_dram_csb   <= w_dram_csb_nxt;
      r_dram_web   <= w_dram_web_nxt;
      r_dram_wmask <= w_dram_wmask_nxt;
      r_dram_addr  <= w_dram_addr_nxt;
      r_dram_din   <= w_dram_din_nxt;
    end
  end

  assign iram_clk0   = wb_clk_i;
  assign dram_clk0   = wb_clk_i;
  assign iram_csb0   = r_iram_csb;
  assign iram_web0   = r_iram_web;
  assign iram_wmask0 = r_iram_wmask;
  assign iram_addr0  = r_iram_addr;
  assign iram_din0   = r_iram_din;
  assign dram_csb0   = r_dram_csb;
  assign dram_web0   = r_dram_web;
  assign dram_wmask0 = r_dram_wmask;
  assign dram_addr0  = r_dram_addr;
  assign dram_din0   = r_dram_din;
  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign o_dbg_state = r_state;

endmodule

// File: doc/rvj1_wb_sram_bridge.md
RVJ1_WB_SRAM_BRIDGE -- requirements
Module: rvj1_wb_sram_bridge

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning the Wishbone byte address of IRAM word 0.
REQ-002 The block SHALL have parameter AW, default `IRAM_ADDR_WIDTH_WORDS (9), meaning the SRAM word-address width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: wb_clk_i input 1, the clock; wb_rst_i input 1, the synchronous active-high reset.
REQ-004 The block SHALL have the following Wishbone classic slave ports: wbs_cyc_i, wbs_stb_i and wbs_we_i, each input 1, the standard cycle, strobe and write-enable.
REQ-005 wbs_sel_i input 4, byte lanes; wbs_adr_i input 32, byte address; wbs_dat_i input 32, write data.
REQ-006 wbs_ack_o output 1, transfer acknowledge; wbs_dat_o output 32, read data.
REQ-007 iram_clk0 and dram_clk0 SHALL each be an output of width 1, driven as a pass-through of wb_clk_i.
REQ-008 iram_csb0 and dram_csb0 SHALL each be an output of width 1, the active-low chip select; iram_web0 and dram_web0 SHALL each be an output of width 1, the active-low write enable.
REQ-009 iram_wmask0 and dram_wmask0 SHALL each be an output of width 4; iram_addr0 and dram_addr0 SHALL each be an output of width AW; iram_din0 and dram_din0 SHALL each be an output of width 32.
REQ-010 iram_dout0 and dram_dout0 SHALL each be an input of width 32, the SRAM read data.

Function
REQ-011 Address decode SHALL be: offset = wbs_adr_i - BASE_ADDR; IRAM when offset < 2^(AW+2); DRAM when 2^(AW+2) <= offset < 2^(AW+3); otherwise unmapped.
REQ-012 SRAM word address SHALL be offset[AW+1:2]; byte-address bits [1:0] SHALL be ignored.
REQ-013 The FSM states SHALL be IDLE, WR_ACK, RD_WAIT and RD_ACK.
REQ-014 In IDLE with cyc&stb, a write SHALL register csb0=0, web0=0, wmask0=wbs_sel_i, addr0 and din0=wbs_dat_i to the decoded SRAM, then go to WR_ACK.
REQ-015 In IDLE with cyc&stb, a read SHALL register csb0=0, web0=1 and addr0 to the decoded SRAM, then go to RD_WAIT.
REQ-016 RD_WAIT SHALL deassert csb0 and go to RD_ACK; RD_ACK SHALL capture the selected doutn into wbs_dat_o and assert wbs_ack_o.
REQ-017 WR_ACK SHALL deassert csb0/web0, assert wbs_ack_o, and return to IDLE.
REQ-018 wbs_ack_o SHALL be high for exactly one cycle per access: write ack 2 cycles after stb is first sampled, read ack 3 cycles after.
REQ-019 csb0 SHALL be low for exactly one cycle per access, and never on both SRAMs simultaneously.
REQ-020 An unmapped access SHALL touch no SRAM, SHALL be acked with the same latency as a mapped access, and a read SHALL return 32'h0.
REQ-021 If wbs_cyc_i drops in any non-IDLE state, the block SHALL return to IDLE next cycle with no ack; an already-issued SRAM write is not undone.
REQ-022 A new request SHALL be sampled only in IDLE; back-to-back requests SHALL incur one IDLE cycle between acks.
REQ-023 wbs_dat_o SHALL hold its last read value outside RD_ACK.

Reset
REQ-024 On reset the block SHALL enter IDLE, with iram/dram csb0=1, web0=1, wmask0=0, addr0=0, din0=0, wbs_ack_o=0 and wbs_dat_o=0.
REQ-025 Reset mid-access SHALL deassert csb0 at the next edge and suppress the pending ack.

Structure
REQ-026 BASE_ADDR, the SRAM word-address widths and the FSM state encodings SHALL live in the shared rvj1_defines include.
REQ-027 The block SHALL contain no sub-module; decode and FSM SHALL be inline, and the target RTL size is 150-250 lines.

Verification
REQ-028 Scenario 1: write 0x3000_0010, data 0xA5A5_1234, sel 4'hF -> iram csb0 low one cycle, addr0=4, din0=0xA5A5_1234; ack 2 cycles later.
REQ-029 Scenario 2: read 0x3000_0810 with the SRAM model holding 0xCAFE_F00D at DRAM word 4 -> dram csb0 low, web0=1; wbs_dat_o=0xCAFE_F00D with ack at cycle 3.
REQ-030 Scenario 3: write with sel=4'b0101 -> wmask0=4'b0101; a readback shows only bytes 0 and 2 changed.
REQ-031 Scenario 4: read 0x3000_1000 (unmapped) -> no csb0 activity; ack at cycle 3 with data 0x0.
REQ-032 Scenario 5: cyc dropped in RD_WAIT -> no ack and FSM in IDLE; the next read completes normally.
REQ-033 Scenario 6: wb_rst_i asserted in WR_ACK -> no ack, all outputs at reset values next cycle; the next access completes normally.
